// File: rtl/fpu_result_queue_if.sv
// Handshake bundle between the FPU result producer, the result queue and the
// downstream consumer.
//
// Handshake rule, both directions: a transfer happens on a rising clk edge
// where valid and ready are both high. valid never depends on ready.
// On the input side a valid word offered while ready is low is lost, and the
// queue counts it as a drop.
//
// Signals:
//   in_valid / in_data / in_status / in_ready       producer -> queue
//   out_valid / out_data / out_status / out_class /
//   out_ready                                       queue -> consumer
//
// Modports:
//   master  producer/consumer side (the testbench or surrounding logic)
//   slave   the queue itself
interface fpu_result_queue_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_status;
  logic        in_ready;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic [1:0]  out_class;

  modport master (
    output in_valid, in_data, in_status, out_ready,
    input  in_ready, out_valid, out_data, out_status, out_class
  );

  modport slave (
    input  in_valid, in_data, in_status, out_ready,
    output in_ready, out_valid, out_data, out_status, out_class
  );
endinterface

// File: rtl/fpu_result_queue.sv
// FPU result queue.
//
// Captures each FPU result word with its 4-bit status in a small FIFO. It
// presents the head entry on a valid/ready port together with a float class
// for the 1/7/24 format: sign [31], exponent [30:24] with bias 63, and
// mantissa [23:0]. It also keeps sticky exception flags and a saturating
// count of results dropped while the queue was full.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   bus           fpu_result_queue_if.slave (input and output handshakes)
//   clr_sticky    synchronous clear of sticky_flags and drop_cnt
//   count         occupied entries, 0..DEPTH
//   sticky_flags  [0] EXACT so far, [3:1] OVERFLOW/UNDERFLOW/INEXACT seen
//   drop_cnt      saturating number of inputs lost while full
module fpu_result_queue #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  fpu_result_queue_if.slave        bus,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               sticky_flags,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] CLS_ZERO      = 2'd0;
  localparam logic [1:0] CLS_SUBNORMAL = 2'd1;
  localparam logic [1:0] CLS_NORMAL    = 2'd2;
  localparam logic [1:0] CLS_MAXEXP    = 2'd3;

  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    stat_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  // Full and empty come from the separate count, because equal pointers are
  // ambiguous between the two states.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Admission depends only on the registered count. A pop in the same cycle
  // does not free a slot for the incoming word.
  assign push = bus.in_valid & ~full;
  assign pop  = ~empty & bus.out_ready;
  assign drop = bus.in_valid & full;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;

  // Storage needs no reset. Its contents are never visible while the queue
  // is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.in_data;
      stat_mem[wr_ptr] <= bus.in_status;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally because DEPTH is a
  // power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags and the drop counter. When clr_sticky and a push occur in
  // the same cycle, the cleared value is the base that the pushed status
  // merges into. When clr_sticky and a drop coincide, the clear wins.
  logic [3:0] sticky_base;

  always_comb begin
    sticky_base = clr_sticky ? 4'b0001 : sticky_flags;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_flags <= 4'b0001;
      drop_cnt     <= '0;
    end else begin
      if (push) begin
        sticky_flags[3:1] <= sticky_base[3:1] | bus.in_status[3:1];
        sticky_flags[0]   <= sticky_base[0] & bus.in_status[0];
      end else begin
        sticky_flags <= sticky_base;
      end

      if (clr_sticky) begin
        drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  // Head presentation. The outputs are forced to zero while the queue is
  // empty, so that a reset immediately shows all-zero outputs and ZERO class.
  logic [31:0] head_data;
  logic [3:0]  head_status;
  logic [6:0]  head_exp;
  logic [23:0] head_mant;

  always_comb begin
    head_data   = '0;
    head_status = '0;
    if (!empty) begin
      head_data   = data_mem[rd_ptr];
      head_status = stat_mem[rd_ptr];
    end
  end

  assign head_exp  = head_data[30:24];
  assign head_mant = head_data[23:0];

  // The sign bit does not affect the class.
  always_comb begin
    bus.out_class = CLS_NORMAL;
    if (head_exp == 7'h00) begin
      bus.out_class = (head_mant == 24'h0) ? CLS_ZERO : CLS_SUBNORMAL;
    end else if (head_exp == 7'h7F) begin
      bus.out_class = CLS_MAXEXP;
    end
  end

  assign bus.out_data   = head_data;
  assign bus.out_status = head_status;

endmodule
